// File: rtl/bus_arbiter_if.sv
// Requester-side bundle for bus_arbiter: requests, one-hot grant and timeout status.
// Purely wires; the arbiter registers every output.
interface bus_arbiter_if #(
    parameter int NOS_REQ = 4,
    parameter int ID_W    = $clog2(NOS_REQ)
) ();
    logic [NOS_REQ-1:0] req;
    logic [NOS_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               bus_busy;
    logic               clr_err;
    logic               timeout_err;
    logic [ID_W-1:0]    err_id;

    modport master (
        output req, clr_err,
        input  grant, grant_id, bus_busy, timeout_err, err_id
    );

    modport slave (
        input  req, clr_err,
        output grant, grant_id, bus_busy, timeout_err, err_id
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin register-bus arbiter with hold timeout; grant one clock after request, one dead cycle on release.
// Requesters hold req until done; a timed-out requester stays blocked until it drops req for a cycle.
module bus_arbiter #(
    parameter int NOS_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int ID_W           = $clog2(NOS_REQ)
) (
    input logic           clk,
    input logic           reset,
    bus_arbiter_if.slave  bus
);
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t             state, stateNxt;
    logic [NOS_REQ-1:0] grantR, grantNxt;
    logic [ID_W-1:0]    grantIdR, grantIdNxt;
    logic               busyR, busyNxt;
    logic [15:0]        holdCnt, holdCntNxt;
    logic [NOS_REQ-1:0] blocked, blockedNxt;
    logic [ID_W-1:0]    lastPtr, lastPtrNxt;
    logic               timeoutErr, timeoutErrNxt;
    logic [ID_W-1:0]    errId, errIdNxt;

    logic [NOS_REQ-1:0] eligible;
    logic               pickFound;
    logic [ID_W-1:0]    pickIdx;
    logic               timeoutHit;
    int                 cand;

    assign eligible = bus.req & ~blocked;

    // Search starts just above the last winner and wraps, giving round-robin order.
    always_comb begin
        pickFound = 1'b0;
        pickIdx   = '0;
        cand      = 0;
        for (int k = 1; k <= NOS_REQ; k++) begin
            cand = int'(lastPtr) + k;
            if (cand >= NOS_REQ) cand = cand - NOS_REQ;
            if (!pickFound && eligible[cand[ID_W-1:0]]) begin
                pickFound = 1'b1;
                pickIdx   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        stateNxt      = state;
        grantNxt      = grantR;
        grantIdNxt    = grantIdR;
        busyNxt       = busyR;
        holdCntNxt    = holdCnt;
        lastPtrNxt    = lastPtr;
        errIdNxt      = errId;
        blockedNxt    = blocked & bus.req;
        timeoutHit    = 1'b0;
        timeoutErrNxt = timeoutErr;

        case (state)
            IDLE: begin
                if (pickFound) begin
                    grantNxt          = '0;
                    grantNxt[pickIdx] = 1'b1;
                    grantIdNxt        = pickIdx;
                    busyNxt           = 1'b1;
                    lastPtrNxt        = pickIdx;
                    holdCntNxt        = '0;
                    stateNxt          = GRANT;
                end
            end
            GRANT: begin
                if (holdCnt != 16'hFFFF) holdCntNxt = holdCnt + 16'd1;
                if (!bus.req[grantIdR]) begin
                    grantNxt = '0;
                    busyNxt  = 1'b0;
                    stateNxt = RELEASE;
                end else if (TO_EN && holdCnt == TO_LAST) begin
                    grantNxt             = '0;
                    busyNxt              = 1'b0;
                    timeoutHit           = 1'b1;
                    errIdNxt             = grantIdR;
                    blockedNxt[grantIdR] = 1'b1;
                    stateNxt             = RELEASE;
                end
            end
            RELEASE: stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase

        // A timeout in the same cycle as clr_err must not be lost.
        if (bus.clr_err) timeoutErrNxt = 1'b0;
        if (timeoutHit)  timeoutErrNxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grantR     <= '0;
            grantIdR   <= '0;
            busyR      <= 1'b0;
            holdCnt    <= '0;
            blocked    <= '0;
            lastPtr    <= ID_W'(NOS_REQ - 1);
            timeoutErr <= 1'b0;
            errId      <= '0;
        end else begin
            state      <= stateNxt;
            grantR     <= grantNxt;
            grantIdR   <= grantIdNxt;
            busyR      <= busyNxt;
            holdCnt    <= holdCntNxt;
            blocked    <= blockedNxt;
            lastPtr    <= lastPtrNxt;
            timeoutErr <= timeoutErrNxt;
            errId      <= errIdNxt;
        end
    end

    assign bus.grant       = grantR;
    assign bus.grant_id    = grantIdR;
    assign bus.bus_busy    = busyR;
    assign bus.timeout_err = timeoutErr;
    assign bus.err_id      = errId;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a cycle-level reference model checked every cycle.
module tb_bus_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_arbiter_if #(.NOS_REQ(N)) bif ();

    bus_arbiter #(.NOS_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bif)
    );

    int tests = 0;
    int fails = 0;
    bit chkOn = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, how long it has held it, and the rules around it.
    int owner   = -1;
    int held    = 0;
    int cool    = 0;
    int last    = N - 1;
    bit blk [N];
    bit mErr    = 1'b0;
    int mErrId  = 0;

    always @(posedge clk) begin
        if (rst) begin
            owner = -1; held = 0; cool = 0; last = N - 1;
            for (int i = 0; i < N; i++) blk[i] = 1'b0;
            mErr = 1'b0; mErrId = 0;
        end else begin
            bit setNow;
            setNow = 1'b0;
            for (int i = 0; i < N; i++) if (!bif.req[i]) blk[i] = 1'b0;
            if (owner >= 0) begin
                held = held + 1;
                if (!bif.req[owner]) begin
                    owner = -1; cool = 1;
                end else if (held == TO) begin
                    blk[owner] = 1'b1; mErrId = owner; setNow = 1'b1;
                    owner = -1; cool = 1;
                end
            end else if (cool > 0) begin
                cool = cool - 1;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (last + k) % N;
                    if (owner < 0 && bif.req[j] && !blk[j]) begin
                        owner = j; held = 0; last = j;
                    end
                end
            end
            if (setNow) mErr = 1'b1;
            else if (bif.clr_err) mErr = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chkOn) begin
            logic [N-1:0] expG;
            expG = (owner >= 0) ? (N'(1) << owner) : '0;
            chk("m_grant", 32'(bif.grant), 32'(expG));
            chk("m_busy", 32'(bif.bus_busy), 32'(owner >= 0));
            if (owner >= 0) chk("m_grant_id", 32'(bif.grant_id), 32'(owner));
            chk("m_err", 32'(bif.timeout_err), 32'(mErr));
            chk("m_err_id", 32'(bif.err_id), 32'(mErrId));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int order[$];
        int widths[$];
        int gaps[$];
        int run, zeros, w;
        logic [N-1:0] prev, g;
        int expOrd [5] = '{0, 1, 2, 3, 0};

        bif.req = '0;
        bif.clr_err = 1'b0;
        rst = 1'b1;
        step(2);
        chkOn = 1'b1;
        chk("rst_grant", 32'(bif.grant), 32'h0);
        chk("rst_grant_id", 32'(bif.grant_id), 32'h0);
        chk("rst_busy", 32'(bif.bus_busy), 32'h0);
        chk("rst_err", 32'(bif.timeout_err), 32'h0);
        chk("rst_err_id", 32'(bif.err_id), 32'h0);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step(1);
            chk("idle_grant", 32'(bif.grant), 32'h0);
            chk("idle_busy", 32'(bif.bus_busy), 32'h0);
        end

        // Single requester: grant held while req high, then release and idle turnaround.
        bif.req = 4'b0100;
        for (int k = 0; k < 7; k++) begin
            step(1);
            chk("single_grant", 32'(bif.grant), 32'h4);
            chk("single_id", 32'(bif.grant_id), 32'd2);
            if (k == 6) bif.req = 4'b0000;
        end
        step(1);
        chk("single_release", 32'(bif.grant), 32'h0);
        step(1);
        chk("single_idle", 32'(bif.grant), 32'h0);

        // Round-robin with everyone requesting; each gives up after 3 clocks.
        rst = 1'b1; step(1); rst = 1'b0;
        bif.req = 4'hF;
        run = 0; zeros = 0; prev = '0;
        for (int c = 0; c < 60 && widths.size() < 5; c++) begin
            step(1);
            g = bif.grant;
            if (g != 0) begin
                if (prev == 0) begin
                    for (int i = 0; i < N; i++) if (g[i]) order.push_back(i);
                    if (order.size() > 1) gaps.push_back(zeros);
                    run = 0;
                end
                run = run + 1;
                zeros = 0;
            end else begin
                if (prev != 0) widths.push_back(run);
                zeros = zeros + 1;
            end
            bif.req = 4'hF;
            if (g != 0 && run == 3) bif.req = 4'hF & ~g;
            prev = g;
        end
        chk("rr_count", 32'(widths.size()), 32'd5);
        for (int i = 0; i < order.size() && i < 5; i++) chk("rr_order", 32'(order[i]), 32'(expOrd[i]));
        for (int i = 0; i < widths.size(); i++) chk("rr_width", 32'(widths[i]), 32'd3);
        for (int i = 0; i < gaps.size() && i < 4; i++) chk("rr_gap", 32'(gaps[i]), 32'd2);

        // Timeout: requester 1 never lets go.
        bif.req = 4'b0000;
        rst = 1'b1; step(1); rst = 1'b0;
        bif.req = 4'b0010;
        w = 0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (bif.grant == 4'b0010) w = w + 1;
            else if (w > 0) break;
            if (c == 3) bif.req = 4'b0011;
        end
        chk("to_width", 32'(w), 32'(TO));
        chk("to_err", 32'(bif.timeout_err), 32'h1);
        chk("to_err_id", 32'(bif.err_id), 32'd1);
        chk("to_release", 32'(bif.grant), 32'h0);
        step(1);
        chk("to_turnaround", 32'(bif.grant), 32'h0);
        step(1);
        chk("to_next", 32'(bif.grant), 32'h1);
        step(3);
        bif.req = 4'b0010;
        step(1);
        for (int c = 0; c < 6; c++) begin
            step(1);
            chk("to_blocked", 32'(bif.grant), 32'h0);
        end
        bif.req = 4'b0000;
        step(1);
        bif.req = 4'b0010;
        step(1);
        chk("to_regrant", 32'(bif.grant), 32'h2);

        // Clear, then a timeout landing on a clr_err pulse, then a clear on the next cycle.
        bif.clr_err = 1'b1;
        step(1);
        bif.clr_err = 1'b0;
        chk("clr_err", 32'(bif.timeout_err), 32'h0);
        step(6);
        bif.clr_err = 1'b1;
        step(1);
        chk("set_wins_err", 32'(bif.timeout_err), 32'h1);
        chk("set_wins_grant", 32'(bif.grant), 32'h0);
        step(1);
        bif.clr_err = 1'b0;
        chk("clr_next_err", 32'(bif.timeout_err), 32'h0);
        chk("clr_next_err_id", 32'(bif.err_id), 32'd1);

        // Reset clears the blocked mask: requester 1 is still high and blocked.
        rst = 1'b1; step(1); rst = 1'b0;
        chk("rst_blk_grant", 32'(bif.grant), 32'h0);
        step(1);
        chk("rst_unblock", 32'(bif.grant), 32'h2);

        // Reset in the middle of a grant drops it with no release cycle.
        bif.req = 4'b0000;
        step(3);
        bif.req = 4'b1000;
        step(1);
        chk("mid_grant", 32'(bif.grant), 32'h8);
        step(5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid_rst_grant", 32'(bif.grant), 32'h0);
        chk("mid_rst_busy", 32'(bif.bus_busy), 32'h0);
        step(1);
        chk("post_rst_grant", 32'(bif.grant), 32'h8);
        chk("post_rst_id", 32'(bif.grant_id), 32'd3);
        bif.req = 4'b0000;
        step(3);

        chkOn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
